pll_lock_ctrl: RTL



---
 rtl/pll_lock_ctrl_pkg.sv | 21 ++
 rtl/pll_lock_ctrl_sync_2ff.sv | 30 +++
 rtl/pll_lock_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller.
package pll_lock_pkg;

  // Controller states, in sequencing order.
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Width of the single shared state counter; all timing parameters fit below 2^17.
  localparam int CNT_W = 17;

  // Diagnostic counter widths and their saturation limits.
  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;
  localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;
  localparam logic [LOSS_W-1:0]  LOSS_MAX  = 8'd255;

endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // One independent two-stage chain per bit; bits are not coherent with each other.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk) begin
      if (rst) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses PLL reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases the core reset. Runs on refclk.
module pll_lock_ctrl
  import pll_lock_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic              sys_reset,
  output logic              ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              locked_s;
  logic              retry_inc;
  logic              loss_inc;

  // The raw PLL lock flag is asynchronous; nothing else looks at it directly.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state decode; relock_req outranks every normal transition.
  always_comb begin
    state_next = state_reg;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    case (state_reg)
      RESET_PLL: begin
        // A relock request here is ignored so the pulse length stays fixed.
        if (cnt_reg == RST_LAST) begin
          state_next = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          state_next = RESET_PLL;
        end else if (locked_s) begin
          state_next = STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = RESET_PLL;
          retry_inc  = 1'b1;
        end
      end
      STABLE: begin
        if (relock_req) begin
          state_next = RESET_PLL;
        end else if (!locked_s) begin
          // A dropout only restarts qualification; the PLL is not reset.
          state_next = WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A loss is recorded even when a relock request lands on the same cycle.
        if (!locked_s) begin
          loss_inc = 1'b1;
        end
        if (relock_req || !locked_s) begin
          state_next = RESET_PLL;
        end
      end
      default: begin
        state_next = RESET_PLL;
      end
    endcase
  end

  // State, shared counter, diagnostics and outputs decoded from the next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= RESET_PLL;
      cnt_reg   <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Counter restarts on every state change; in RUN it free-runs and its value is unused.
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (retry_inc && (retry_cnt != RETRY_MAX)) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end
      if (loss_inc && (loss_cnt != LOSS_MAX)) begin
        loss_cnt <= loss_cnt + LOSS_W'(1);
      end
      pll_rst   <= (state_next == RESET_PLL);
      sys_reset <= (state_next != RUN);
      ready     <= (state_next == RUN);
    end
  end

endmodule
